// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stream controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

   // Controller state encoding (2-bit, IDLE..DONE = 0..3)
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_STAGES = 2;
   localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/pipe_valid_chain.sv
// Per-stage valid tracking, ready chain and load-enable generation for a STAGES-deep pipe.
// Latency: an item loaded into stage i is in stage i+1 one cycle later when not blocked.
// Backpressure: out_ready low freezes the tail; empty stages upstream still fill (bubble collapse).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         synchronous clear of all valid bits
//   in_fire       an operand enters stage 0 this cycle
//   out_ready     consumer takes the last stage's item this cycle
//   stage_valid   per-stage valid bits (bit 0 = first stage)
//   ld_en         per-stage register load enables
//   rdy0          stage 0 can take a new item this cycle
module pipe_valid_chain
   import pipe_ctrl_pkg::*;
#(
   parameter int STAGES = DEF_STAGES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_fire,
   input  logic              out_ready,
   output logic [STAGES-1:0] stage_valid,
   output logic [STAGES-1:0] ld_en,
   output logic              rdy0
);

   logic [STAGES-1:0] rdy;
   logic [STAGES-1:0] drained;
   logic [STAGES-1:0] valid_nxt;

   // Ready ripples from the tail: a stage can accept when it is empty or
   // its current occupant is itself moving on this cycle.
   always_comb begin
      rdy = '0;
      rdy[STAGES-1] = !stage_valid[STAGES-1] | out_ready;
      for (int i = STAGES - 2; i >= 0; i--) begin
         rdy[i] = !stage_valid[i] | rdy[i+1];
      end
   end

   always_comb begin
      ld_en    = '0;
      ld_en[0] = in_fire;
      for (int i = 1; i < STAGES; i++) begin
         ld_en[i] = stage_valid[i-1] & rdy[i];
      end
   end

   // A stage is drained when its item moves downstream (or leaves the tail).
   always_comb begin
      drained = '0;
      for (int i = 0; i < STAGES - 1; i++) begin
         drained[i] = ld_en[i+1];
      end
      drained[STAGES-1] = stage_valid[STAGES-1] & out_ready;
   end

   // Every load carries a valid item, so a load always sets the bit;
   // otherwise the bit holds unless the item moved on.
   always_comb begin
      valid_nxt = '0;
      for (int i = 0; i < STAGES; i++) begin
         valid_nxt[i] = ld_en[i] | (stage_valid[i] & !drained[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_valid <= '0;
      end else if (flush) begin
         stage_valid <= '0;
      end else begin
         stage_valid <= valid_nxt;
      end
   end

   assign rdy0 = rdy[0];

endmodule

// File: rtl/pipe_stream_ctrl.sv
// Pipeline controller for the MAC datapath: run FSM, operand counters and per-stage load enables.
// Latency: operand accepted at edge k reaches out_valid after edge k+STAGES-1; 1 operand/cycle.
// Backpressure: out_ready low stalls the tail, bubbles collapse, in_ready drops once the pipe is full.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   inner_rst       synchronous flush, overrides every other input
//   start, len      arm a run of len operands (sampled in IDLE only)
//   in_valid/in_ready    producer handshake
//   out_valid/out_ready  consumer handshake on the last stage; out_last marks result len
//   ld_en, stage_valid   per-stage load enables and valid bits
//   pipe_stall, busy, done  status; done is a one-cycle pulse
module pipe_stream_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int STAGES = DEF_STAGES,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inner_rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              out_ready,
   output logic              out_valid,
   output logic              out_last,
   output logic [STAGES-1:0] ld_en,
   output logic [STAGES-1:0] stage_valid,
   output logic              pipe_stall,
   output logic              busy,
   output logic              done
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] in_cnt;
   logic [CNT_W-1:0] out_cnt;
   logic [CNT_W-1:0] len_q;
   logic             rdy0;
   logic             in_fire;
   logic             out_fire;

   pipe_valid_chain #(
      .STAGES (STAGES)
   ) u_chain (
      .clk         (clk),
      .rst         (rst),
      .flush       (inner_rst),
      .in_fire     (in_fire),
      .out_ready   (out_ready),
      .stage_valid (stage_valid),
      .ld_en       (ld_en),
      .rdy0        (rdy0)
   );

   assign in_ready   = (state == RUN) & rdy0;
   assign in_fire    = in_valid & in_ready;
   assign out_valid  = stage_valid[STAGES-1];
   assign out_fire   = out_valid & out_ready;
   assign out_last   = out_valid & ((out_cnt + CNT_ONE) == len_q);
   assign pipe_stall = out_valid & !out_ready;
   assign busy       = (state == RUN) | (state == DRAIN);
   assign done       = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         in_cnt  <= '0;
         out_cnt <= '0;
         len_q   <= '0;
      end else if (inner_rst) begin
         state   <= IDLE;
         in_cnt  <= '0;
         out_cnt <= '0;
         len_q   <= '0;
      end else begin
         if (in_fire) begin
            in_cnt <= in_cnt + CNT_ONE;
         end
         if (out_fire) begin
            out_cnt <= out_cnt + CNT_ONE;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     state   <= RUN;
                     len_q   <= len;
                     in_cnt  <= '0;
                     out_cnt <= '0;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            RUN: begin
               if (in_fire && ((in_cnt + CNT_ONE) == len_q)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // Pipe empty and every result handed over.
               if ((stage_valid == '0) && (out_cnt == len_q)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stream_ctrl.sv
module tb_pipe_stream_ctrl;

   localparam int S  = 3;
   localparam int CW = 8;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          inner_rst;
   logic          start;
   logic [CW-1:0] len;
   logic          in_valid;
   logic          in_ready;
   logic          out_ready;
   logic          out_valid;
   logic          out_last;
   logic [S-1:0]  ld_en;
   logic [S-1:0]  stage_valid;
   logic          pipe_stall;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stream_ctrl #(
      .STAGES (S),
      .CNT_W  (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .inner_rst   (inner_rst),
      .start       (start),
      .len         (len),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_last    (out_last),
      .ld_en       (ld_en),
      .stage_valid (stage_valid),
      .pipe_stall  (pipe_stall),
      .busy        (busy),
      .done        (done)
   );

   // Bit order: in_ready, out_valid, out_last, pipe_stall, busy, done, ld_en[2:0], stage_valid[2:0]
   logic [11:0] got_vec;
   logic [11:0] exp_vec;
   assign got_vec = {in_ready, out_valid, out_last, pipe_stall, busy, done, ld_en, stage_valid};

   // Reference model: each pipe slot holds the sequence number of the item
   // in it (-1 = empty). Items advance into free slots, the tail leaves when
   // the consumer is ready, and a new item enters slot 0 if it ends up free.
   int m_state, m_in_cnt, m_out_cnt, m_len;
   int slot[S];
   int n_state, n_in, n_out, n_len;
   int n_slot[S];

   // run_stream observations
   int c_in_fire, c_out_fire, c_done, c_last_pos, c_ir_cnt, c_ov_cnt;
   int c_first_in, c_first_out;
   bit c_full_stall;
   logic [S-1:0] sv_log[64];
   logic         ir_log[64];

   task automatic model_reset();
      m_state   = M_IDLE;
      m_in_cnt  = 0;
      m_out_cnt = 0;
      m_len     = 0;
      foreach (slot[i]) slot[i] = -1;
   endtask

   task automatic drive(input logic s, input logic [CW-1:0] l, input logic iv,
                        input logic orr, input logic fl);
      int ns[S];
      logic [S-1:0] ent;
      logic [S-1:0] occ;
      logic e_ir, e_if, e_of, e_ov, e_last;
      start     = s;
      len       = l;
      in_valid  = iv;
      out_ready = orr;
      inner_rst = fl;
      ns  = slot;
      ent = '0;
      e_of = 1'b0;
      if (slot[S-1] >= 0 && orr) begin
         ns[S-1] = -1;
         e_of = 1'b1;
      end
      for (int i = S - 2; i >= 0; i--) begin
         if (ns[i] >= 0 && ns[i+1] < 0) begin
            ns[i+1]  = ns[i];
            ns[i]    = -1;
            ent[i+1] = 1'b1;
         end
      end
      e_ir = (m_state == M_RUN) && (ns[0] < 0);
      e_if = e_ir && iv;
      if (e_if) begin
         ns[0]  = m_in_cnt;
         ent[0] = 1'b1;
      end
      for (int i = 0; i < S; i++) occ[i] = (slot[i] >= 0);
      e_ov   = (slot[S-1] >= 0);
      e_last = e_ov && (slot[S-1] == m_len - 1);
      exp_vec = {e_ir, e_ov, e_last, (e_ov && !orr),
                 (m_state == M_RUN || m_state == M_DRAIN), (m_state == M_DONE), ent, occ};
      n_slot  = ns;
      n_in    = m_in_cnt + int'(e_if);
      n_out   = m_out_cnt + int'(e_of);
      n_len   = m_len;
      n_state = m_state;
      case (m_state)
         M_IDLE: begin
            if (s) begin
               if (l != '0) begin
                  n_state = M_RUN;
                  n_len   = int'(l);
                  n_in    = 0;
                  n_out   = 0;
               end else begin
                  n_state = M_DONE;
               end
            end
         end
         M_RUN:   if (e_if && (m_in_cnt + 1 == m_len)) n_state = M_DRAIN;
         M_DRAIN: if (occ == '0 && m_out_cnt == m_len) n_state = M_DONE;
         default: n_state = M_IDLE;
      endcase
      if (fl) begin
         n_state = M_IDLE;
         n_in    = 0;
         n_out   = 0;
         n_len   = 0;
         foreach (n_slot[i]) n_slot[i] = -1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      m_state   = n_state;
      m_in_cnt  = n_in;
      m_out_cnt = n_out;
      m_len     = n_len;
      slot      = n_slot;
   endtask

   // mode 0 streaming, 1 mid-stream backpressure, 2 bubble pattern, 3 random
   task automatic run_stream(input int mode, input int l, input int budget);
      logic iv, orr, s;
      int tail;
      bit fin;
      c_in_fire = 0; c_out_fire = 0; c_done = 0; c_last_pos = -1;
      c_ir_cnt = 0; c_ov_cnt = 0; c_first_in = -1; c_first_out = -1;
      c_full_stall = 1'b0;
      tail = 0;
      fin  = 1'b0;
      drive(1'b1, CW'(l), 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if (got_vec !== exp_vec) begin
         bad++;
         $display("FAIL stream_start mode=%0d got=%b exp=%b", mode, got_vec, exp_vec);
      end
      step();
      for (int cyc = 0; cyc < budget && !fin; cyc++) begin
         case (mode)
            0:       begin iv = 1'b1; orr = 1'b1; end
            1:       begin iv = 1'b1; orr = !(cyc >= 3 && cyc < 7); end
            2:       begin iv = (cyc < 5) ? (cyc % 2 == 0) : 1'b1; orr = (cyc >= 8); end
            default: begin iv = ($urandom % 4 != 0); orr = ($urandom % 3 != 0); end
         endcase
         // start/len outside IDLE must be ignored
         s = (mode == 3 && (m_state == M_RUN || m_state == M_DRAIN)) ? 1'($urandom % 2) : 1'b0;
         drive(s, CW'($urandom), iv, orr, 1'b0);
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec) begin
            bad++;
            $display("FAIL stream mode=%0d cyc=%0d got=%b exp=%b", mode, cyc, got_vec, exp_vec);
         end
         if (in_valid && in_ready) begin
            if (c_first_in < 0) c_first_in = cyc;
            c_in_fire++;
         end
         if (out_valid) begin
            c_ov_cnt++;
            if (c_first_out < 0) c_first_out = cyc;
         end
         if (out_valid && out_ready) begin
            c_out_fire++;
            if (out_last) c_last_pos = c_out_fire;
         end
         if (in_ready) c_ir_cnt++;
         if (stage_valid == 3'b111 && pipe_stall && ld_en == 3'b000 && !in_ready)
            c_full_stall = 1'b1;
         if (cyc < 64) begin
            sv_log[cyc] = stage_valid;
            ir_log[cyc] = in_ready;
         end
         if (done) c_done++;
         if (c_done > 0) tail++;
         if (tail >= 4) fin = 1'b1;
         step();
      end
      total++;
      if (!fin) begin
         bad++;
         $display("FAIL stream_timeout mode=%0d len=%0d done_seen=%0d required=1", mode, l, c_done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; inner_rst = 1'b0; start = 1'b0; len = '0;
      in_valid = 1'b0; out_ready = 1'b0;
      #12;
      total++;
      if (got_vec !== 12'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%b exp=%b", got_vec, 12'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if (got_vec !== exp_vec) begin
         bad++;
         $display("FAIL reset_idle got=%b exp=%b", got_vec, exp_vec);
      end
      step();
   endtask

   task automatic test_streaming();
      run_stream(0, 4, 100);
      total++; if (c_in_fire != 4)   begin bad++; $display("FAIL stream_in_fire got=%0d exp=4", c_in_fire); end
      total++; if (c_out_fire != 4)  begin bad++; $display("FAIL stream_out_fire got=%0d exp=4", c_out_fire); end
      total++; if (c_last_pos != 4)  begin bad++; $display("FAIL stream_last_pos got=%0d exp=4", c_last_pos); end
      total++; if (c_done != 1)      begin bad++; $display("FAIL stream_done got=%0d exp=1", c_done); end
      total++; if (c_ir_cnt != 4)    begin bad++; $display("FAIL stream_in_ready_cycles got=%0d exp=4", c_ir_cnt); end
      total++; if (c_ov_cnt != 4)    begin bad++; $display("FAIL stream_out_valid_cycles got=%0d exp=4", c_ov_cnt); end
      // accepted in sample cycle c -> tail valid in sample cycle c+S
      total++;
      if (c_first_out - c_first_in != S) begin
         bad++;
         $display("FAIL stream_latency got=%0d exp=%0d", c_first_out - c_first_in, S);
      end
   endtask

   task automatic test_backpressure();
      run_stream(1, 6, 100);
      total++; if (c_in_fire != 6)  begin bad++; $display("FAIL bp_in_fire got=%0d exp=6", c_in_fire); end
      total++; if (c_out_fire != 6) begin bad++; $display("FAIL bp_out_fire got=%0d exp=6", c_out_fire); end
      total++; if (c_last_pos != 6) begin bad++; $display("FAIL bp_last_pos got=%0d exp=6", c_last_pos); end
      total++; if (c_done != 1)     begin bad++; $display("FAIL bp_done got=%0d exp=1", c_done); end
      total++; if (!c_full_stall)   begin bad++; $display("FAIL bp_full_stall got=0 exp=1"); end
   endtask

   task automatic test_bubble_collapse();
      run_stream(2, 5, 100);
      total++; if (sv_log[4] !== 3'b110) begin bad++; $display("FAIL bubble_sv4 got=%b exp=110", sv_log[4]); end
      total++; if (sv_log[5] !== 3'b111) begin bad++; $display("FAIL bubble_sv5 got=%b exp=111", sv_log[5]); end
      for (int k = 0; k < 5; k++) begin
         total++;
         if (ir_log[k] !== 1'b1) begin bad++; $display("FAIL bubble_in_ready cyc=%0d got=%b exp=1", k, ir_log[k]); end
      end
      total++; if (ir_log[5] !== 1'b0) begin bad++; $display("FAIL bubble_full_in_ready got=%b exp=0", ir_log[5]); end
      total++; if (c_out_fire != 5)    begin bad++; $display("FAIL bubble_out_fire got=%0d exp=5", c_out_fire); end
   endtask

   task automatic test_zero_len();
      run_stream(0, 0, 20);
      total++; if (c_done != 1)    begin bad++; $display("FAIL zero_done got=%0d exp=1", c_done); end
      total++; if (c_ir_cnt != 0)  begin bad++; $display("FAIL zero_in_ready got=%0d exp=0", c_ir_cnt); end
      total++; if (c_out_fire != 0) begin bad++; $display("FAIL zero_out_fire got=%0d exp=0", c_out_fire); end
   endtask

   task automatic test_flush();
      drive(1'b1, 8'd8, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      step();
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec) begin bad++; $display("FAIL flush_fill k=%0d got=%b exp=%b", k, got_vec, exp_vec); end
         step();
      end
      drive(1'b1, 8'd5, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      total++;
      if (stage_valid !== 3'b011) begin bad++; $display("FAIL flush_inflight got=%b exp=011", stage_valid); end
      step();
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if ({stage_valid, busy, in_ready, done} !== 6'd0) begin
         bad++;
         $display("FAIL flush_cleared sv/busy/in_ready/done got=%b exp=000000", {stage_valid, busy, in_ready, done});
      end
      step();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec) begin bad++; $display("FAIL flush_idle k=%0d got=%b exp=%b", k, got_vec, exp_vec); end
         step();
      end
      run_stream(0, 3, 100);
      total++; if (c_in_fire != 3)  begin bad++; $display("FAIL flush_rerun_in got=%0d exp=3", c_in_fire); end
      total++; if (c_last_pos != 3) begin bad++; $display("FAIL flush_rerun_last got=%0d exp=3", c_last_pos); end
      total++; if (c_done != 1)     begin bad++; $display("FAIL flush_rerun_done got=%0d exp=1", c_done); end
   endtask

   task automatic test_random();
      int l;
      for (int r = 0; r < 7; r++) begin
         l = (r == 6) ? 255 : int'($urandom_range(1, 40));
         run_stream(3, l, 3000);
         total++; if (c_in_fire != l)  begin bad++; $display("FAIL rand_in_fire run=%0d got=%0d exp=%0d", r, c_in_fire, l); end
         total++; if (c_out_fire != l) begin bad++; $display("FAIL rand_out_fire run=%0d got=%0d exp=%0d", r, c_out_fire, l); end
         total++; if (c_last_pos != l) begin bad++; $display("FAIL rand_last_pos run=%0d got=%0d exp=%0d", r, c_last_pos, l); end
         total++; if (c_done != 1)     begin bad++; $display("FAIL rand_done run=%0d got=%0d exp=1", r, c_done); end
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 8'd4, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      step();
      for (int k = 0; k < 20 && m_state != M_DRAIN; k++) begin
         drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
         @(negedge clk);
         step();
      end
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || stage_valid === 3'b000) begin
         bad++;
         $display("FAIL areset_pre_drain busy=%b sv=%b exp busy=1 sv!=000", busy, stage_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (got_vec !== 12'd0) begin bad++; $display("FAIL areset_immediate got=%b exp=%b", got_vec, 12'd0); end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
         @(negedge clk);
         total++;
         if (got_vec !== exp_vec || busy !== 1'b0) begin
            bad++;
            $display("FAIL areset_idle k=%0d got=%b exp=%b", k, got_vec, exp_vec);
         end
         step();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_streaming();
      test_backpressure();
      test_bubble_collapse();
      test_zero_len();
      test_flush();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog elapsed before end of sequence");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pipe_stream_ctrl.md
Name: pipe_stream_ctrl

Overview:
- Parametrised pipeline controller for the multiply/accumulate datapath. Generalises the two-state WAIT/PIPE controller to STAGES pipeline stages.
- Tracks a per-stage valid bit and emits per-stage load enables. Supports stall with bubble collapse under output backpressure.
- Counts a programmed number of operands in and out, drains the pipe, then pulses done.
- Sits between the operand fetch logic (producer) and the accumulator/writeback logic (consumer).

Parameters:
STAGES, 2, number of pipeline register stages controlled (>=1)
CNT_W, 8, width of operand length and counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
inner_rst  in  1  synchronous flush; priority over all other inputs
start  in  1  arm a run of len operands; sampled only in IDLE
len  in  CNT_W  operand count; latched on start in IDLE
in_valid  in  1  producer has an operand (successor of can_mult)
in_ready  out  1  controller accepts operand this cycle
out_ready  in  1  consumer can take the result in the last stage
out_valid  out  1  last stage holds a valid result
out_last  out  1  out_valid and this is result number len
ld_en  out  STAGES  per-stage register load enable (bit 0 = first stage)
stage_valid  out  STAGES  per-stage valid bits
pipe_stall  out  1  a valid item is blocked this cycle
busy  out  1  state is RUN or DRAIN
done  out  1  one-cycle pulse, state DONE

Behaviour:
- Reset (rst async, or inner_rst on the clock edge):
  - state = IDLE; stage_valid, in_cnt, out_cnt, len_q all 0.
  - Consequently in_ready, out_valid, out_last, ld_en, pipe_stall, busy and done are 0.
- States: IDLE, RUN, DRAIN, DONE. 2-bit encoding 0..3.
  - IDLE:
    - start=1 and len!=0 -> RUN, latch len_q = len.
    - start=1 and len==0 -> DONE.
    - Otherwise stay in IDLE.
  - RUN -> DRAIN on the edge that accepts operand number len_q (in_cnt+1 == len_q with in_fire).
  - DRAIN -> DONE on the first edge where stage_valid == 0 and out_cnt == len_q.
  - DONE -> IDLE unconditionally after 1 cycle.
  - start outside IDLE is ignored.
- Ready chain (combinational):
  - rdy[S-1] = !stage_valid[S-1] | out_ready.
  - rdy[i] = !stage_valid[i] | rdy[i+1].
- Handshakes:
  - in_ready = (state==RUN) & rdy[0].
  - in_fire = in_valid & in_ready.
  - out_valid = stage_valid[S-1].
  - out_fire = out_valid & out_ready.
- Load enables:
  - ld_en[0] = in_fire.
  - ld_en[i>0] = stage_valid[i-1] & rdy[i].
- Valid update:
  - Stage i with ld_en[i] takes the upstream valid.
  - Stage i that is emptied downstream without a reload clears to 0.
  - Otherwise stage i holds.
  - Bubbles collapse: an empty stage loads even if downstream is stalled.
- Latency:
  - Operand accepted at edge k: stage_valid[0] high after edge k.
  - With no backpressure, out_valid is high after edge k+STAGES-1.
  - Throughput is 1 operand/cycle.
- pipe_stall = out_valid & !out_ready. Asserted in RUN or DRAIN whenever the tail is blocked.
- Counters:
  - in_cnt increments on in_fire; out_cnt increments on out_fire. Both clear on entry to RUN.
  - Neither counter wraps within a run, because len_q bounds them.
- out_last = out_fire-eligible item: out_valid & (out_cnt+1 == len_q).
- Simultaneous events:
  - inner_rst with start: the flush wins and start is lost.
  - in_fire and out_fire in the same cycle with a full pipe: allowed, all ld_en=1, occupancy unchanged.
  - Reset mid-RUN or mid-DRAIN: in-flight items are discarded and no done pulse occurs.
- No data path inside: datapath registers use ld_en only.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3;
  - default STAGES and CNT_W.
- Sub-module pipe_valid_chain (parameter STAGES) holds the valid register array, the ready chain and the ld_en generation.
  - Inputs: clk, rst, flush, in_fire, out_ready.
  - Outputs: stage_valid, ld_en, rdy0.
- The top level keeps the FSM and the counters.

Test Plan:
- Streaming: STAGES=3, len=4, in_valid=1, out_ready=1.
  - in_ready high 4 cycles; out_valid first high 2 cycles after the first acceptance, then 4 consecutive cycles.
  - out_last on the 4th result; done pulses exactly 1 cycle; total 4 in_fire and 4 out_fire.
- Backpressure: STAGES=3, len=6, out_ready low for 4 cycles mid-stream.
  - Pipe fills to stage_valid=3'b111 and in_ready drops; pipe_stall=1 and ld_en=3'b000 while full.
  - After release all 6 results arrive in order, none lost or duplicated.
- Bubble collapse: in_valid=1,0,1,0 with out_ready=0.
  - Items compact to stage_valid=3'b110 then 3'b111; in_ready stays 1 until full.
- Zero length: start with len=0.
  - IDLE -> DONE -> IDLE; done pulses 1 cycle; in_ready never asserts.
- Flush: inner_rst in RUN with 2 items in flight, and start high in the same cycle.
  - Next cycle stage_valid=0, state IDLE, counters 0, no done pulse.
  - A new start then begins a clean run.
- Async reset mid-DRAIN: assert rst between clock edges.
  - All outputs 0 immediately, without waiting for a clock edge; the controller stays IDLE after release.
